// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: access size encoding, FSM states, lane masks.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [3:0] LANE_NONE = 4'b0000;
    localparam logic [3:0] LANE_B0   = 4'b0001;
    localparam logic [3:0] LANE_HLO  = 4'b0011;
    localparam logic [3:0] LANE_HHI  = 4'b1100;
    localparam logic [3:0] LANE_ALL  = 4'b1111;

    function automatic logic [1:0] port_onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: store strobes/replication and load extraction/extension.
module dmem_lane_fmt
    import dmem_arb_pkg::*;
(
    input  size_e       size,
    input  logic        uns,
    input  logic [1:0]  ofs,
    input  logic [31:0] wdata,
    input  logic [31:0] rd,
    output logic [3:0]  wmask,
    output logic [31:0] wd,
    output logic [31:0] rdata
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = rd >> {ofs, 3'b000};
        b       = shifted[7:0];
        h       = ofs[1] ? rd[31:16] : rd[15:0];
        wmask   = LANE_NONE;
        wd      = 32'h0;
        rdata   = 32'h0;
        case (size)
            SZ_BYTE: begin
                wmask = LANE_B0 << ofs;
                wd    = {4{wdata[7:0]}};
                rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
            end
            SZ_HALF: begin
                wmask = ofs[1] ? LANE_HHI : LANE_HLO;
                wd    = {2{wdata[15:0]}};
                rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            SZ_WORD: begin
                wmask = LANE_ALL;
                wd    = wdata;
                rdata = rd;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grant at T, memory access at T+1, registered completion at T+2.
// Define DMEM_ARB_RR_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [1:0][1:0]  size,
    input  logic [1:0]       uns,
    input  logic [1:0][31:0] addr,
    input  logic [1:0][31:0] wdata,
    output logic [1:0]       gnt,
    output logic [1:0]       rvalid,
    output logic [31:0]      rdata,
    output logic             err,
    output logic [3:0]       mem_wmask,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd
);

    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    state_e      state, state_nxt;
    logic        win;
    logic        busy;
    logic        fault;
    logic        c_port, c_we, c_uns;
    size_e       c_size;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  fmt_wmask;
    logic [31:0] fmt_wd, fmt_rdata;

`ifdef DMEM_ARB_RR_EN
    logic ptr;

    // ptr names the port that wins the next tie: the one not granted last
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (gnt != 2'b00)
            ptr <= ~win;
    end

    assign win = (req == 2'b11) ? ptr : req[1];
`else
    assign win = (req == 2'b10);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req != 2'b00) state_nxt = ST_BUSY;
            ST_BUSY: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_BUSY);

    always_comb begin
        gnt       = 2'b00;
        mem_addr  = 32'h0;
        mem_wd    = 32'h0;
        mem_wmask = LANE_NONE;
        if (state == ST_IDLE && req != 2'b00)
            gnt = port_onehot(win);
        if (busy) begin
            mem_addr = {c_addr[31:2], 2'b00};
            mem_wd   = fmt_wd;
            if (c_we && !fault)
                mem_wmask = fmt_wmask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_port  <= 1'b0;
            c_we    <= 1'b0;
            c_uns   <= 1'b0;
            c_size  <= SZ_BYTE;
            c_addr  <= 32'h0;
            c_wdata <= 32'h0;
        end else if (state == ST_IDLE && req != 2'b00) begin
            c_port  <= win;
            c_we    <= we[win];
            c_uns   <= uns[win];
            c_size  <= size_e'(size[win]);
            c_addr  <= addr[win];
            c_wdata <= wdata[win];
        end
    end

    always_comb begin
        fault = 1'b0;
        case (c_size)
            SZ_HALF: fault = c_addr[0];
            SZ_WORD: fault = (c_addr[1:0] != 2'b00);
            SZ_ILL:  fault = 1'b1;
            default: ;
        endcase
        if ({1'b0, c_addr} >= ADDR_LIMIT)
            fault = 1'b1;
    end

    dmem_lane_fmt u_fmt (
        .size  (c_size),
        .uns   (c_uns),
        .ofs   (c_addr[1:0]),
        .wdata (c_wdata),
        .rd    (mem_rd),
        .wmask (fmt_wmask),
        .wd    (fmt_wd),
        .rdata (fmt_rdata)
    );

    // Completion outputs are zero whenever no access finished in the previous cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 2'b00;
            rdata  <= 32'h0;
            err    <= 1'b0;
        end else if (busy) begin
            rvalid <= port_onehot(c_port);
            rdata  <= (fault || c_we) ? 32'h0 : fmt_rdata;
            err    <= fault;
        end else begin
            rvalid <= 2'b00;
            rdata  <= 32'h0;
            err    <= 1'b0;
        end
    end

endmodule
